hex_display_updater: RTL and testbench
======================================

# hex_display_updater

Avalon-MM master that refreshes the bank of seven-segment HEX PIO slaves from a single packed numeric request. It accepts a value and decimal-point mask from fabric logic, encodes each nibble to an active-low segment code with optional leading-zero blanking, and issues one sequenced write per digit to the PIO register at offset 0. It sits beside the Nios II data master on the system interconnect, so it must tolerate `avm_waitrequest` stalls.

## Interface
- `NUM_DIGITS`, 6, number of HEX PIO slaves driven (1..8).
- `BASE_ADDR`, 32'h0000_3000, byte address of digit 0's PIO register 0.
- `STRIDE`, 16, byte spacing between consecutive digit PIO slaves.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_value`  in  4*NUM_DIGITS  packed nibbles; nibble i goes to digit i.
- `req_dp_mask`  in  NUM_DIGITS  bit i=1 lights the decimal point of digit i.
- `req_blank_lz`  in  1  enables leading-zero blanking.
- `avm_address`  out  32  write address.
- `avm_write`  out  1  write strobe.
- `avm_writedata`  out  32  `{24'b0, seg_code}`.
- `avm_waitrequest`  in  1  slave stall.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last digit write completes.

## Operation
- The FSM has three states: IDLE, WRITE and DONE.
- **IDLE**
  - `req_ready`=1.
  - On accept, capture `req_value`, `req_dp_mask` and `req_blank_lz`, set digit index `idx`=0, and go to WRITE.
- **WRITE**
  - `avm_write`=1.
  - `avm_address` = BASE_ADDR + idx*STRIDE.
  - `avm_writedata` = `{24'b0, code(idx)}`.
  - If `avm_waitrequest`=1, hold the state and all `avm_*` outputs unchanged.
  - If `avm_waitrequest`=0 and idx == NUM_DIGITS-1, go to DONE.
  - If `avm_waitrequest`=0 and idx < NUM_DIGITS-1, increment idx.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Segment code**
  - Active-low encoding: bit0..6 = segments a..g, bit7 = DP.
  - Hex digits 0–F map to C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - A set DP bit clears bit7 of the code.
  - A blanked digit is FF.
- **Blanking rule**, evaluated on the captured registers:
  - Digit i>0 is blanked iff `blank_lz`=1, all nibbles at indices ≥ i are zero, and all DP bits at indices ≥ i are zero.
  - Digit 0 is never blanked.
- Outside WRITE, `avm_write`, `avm_address` and `avm_writedata` are 0.
- `req_valid` while not IDLE is ignored. Requests are not queued.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `busy`=0, `done`=0, all `avm_*` outputs 0, captured registers 0.
- **Latency, no stalls:**
  - Accept at edge k.
  - WRITE occupies cycles k+1 .. k+NUM_DIGITS.
  - `done` is high in cycle k+NUM_DIGITS+1.
  - `req_ready` rises at k+NUM_DIGITS+2.
  - Minimum request-to-request spacing is NUM_DIGITS+2 cycles.
- Each stall cycle adds exactly one cycle to the latency.
- **Reset mid-sequence:**
  - `avm_write` drops asynchronously and the FSM returns to IDLE.
  - Digits already written keep their PIO values; no rollback is performed.
- `avm_*` outputs are decoded from state, idx and captured registers only. They have no combinational path from `req_*` or `avm_waitrequest`.

## Structure
- Package `hex_display_pkg` holds:
  - the state enum;
  - the segment constants `SEG_BLANK`=8'hFF and `SEG_DP_BIT`=7;
  - the 16-entry nibble-to-code function.
- Sub-module `hex7seg_encoder`: inputs nibble, dp and blank; output 8-bit code. It is instantiated once and driven by the current idx.
- The top module contains the FSM, the idx counter, the capture registers and the blanking logic.

## Test plan
- **Basic write sequence:** `req_value`=24'h012345, dp=0, lz=1, waitrequest=0.
  - Writes go to offsets 0x00..0x50 with data 92, 99, B0, A4, F9, FF.
  - `done` is high at cycle k+7.
- **Stall handling:** same request with waitrequest held high 3 cycles during digit 2.
  - Address 0x20 and data B0 stay stable throughout the stall.
  - `done` moves to k+10.
- **Blanking with DP:** value 0, dp_mask=6'b000100, lz=1.
  - Data sequence is C0, C0, 40, FF, FF, FF.
- **No blanking:** value 24'hFFFFFF, dp_mask=6'h3F, lz=0.
  - All six writes carry data 0E.
- **Busy/back-to-back:** `req_valid` held high continuously.
  - Second accept occurs exactly at k+8.
  - A different value presented mid-sequence is not captured.
- **Reset mid-sequence:** assert reset_n=0 during the digit-3 write.
  - `avm_write` goes to 0 immediately.
  - After release, `req_ready`=1.
  - The next request starts its writes at offset 0x00.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and segment encoding for the HEX display updater.
package hex_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam int         SEG_DP_BIT = 7;

   // Active-low a..g in bits 0..6, DP (bit 7) left dark.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_display_updater_hex7seg_encoder.sv
// Single-digit encoder: nibble + DP + blank -> active-low segment byte.
module hex7seg_encoder
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] code
);

   // Blank overrides everything; a lit DP pulls bit 7 low.
   always_comb begin
      code = hex_to_seg(nibble);
      if (dp)
         code[SEG_DP_BIT] = 1'b0;
      if (blank)
         code = SEG_BLANK;
   end

endmodule

// File: rtl/hex_display_updater.sv
// Avalon-MM master that writes one segment code per HEX PIO slave.
module hex_display_updater
   import hex_display_pkg::*;
#(
   parameter int          NUM_DIGITS = 6,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int unsigned STRIDE     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [4*NUM_DIGITS-1:0] req_value,
   input  logic [NUM_DIGITS-1:0]   req_dp_mask,
   input  logic                    req_blank_lz,
   output logic [31:0]             avm_address,
   output logic                    avm_write,
   output logic [31:0]             avm_writedata,
   input  logic                    avm_waitrequest,
   output logic                    busy,
   output logic                    done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] cap_value;
   logic [NUM_DIGITS-1:0]   cap_dp;
   logic                    cap_blank_lz;

   logic [NUM_DIGITS-1:0]   tail_zero;
   logic [3:0]              cur_nibble;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [7:0]              cur_code;

   // State, digit index and request capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         idx          <= '0;
         cap_value    <= '0;
         cap_dp       <= '0;
         cap_blank_lz <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && req_valid) begin
            idx          <= '0;
            cap_value    <= req_value;
            cap_dp       <= req_dp_mask;
            cap_blank_lz <= req_blank_lz;
         end else if (state == ST_WRITE && !avm_waitrequest && idx != LAST_IDX) begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   // tail_zero[i]: every nibble and DP bit from digit i upward is zero.
   always_comb begin
      logic run;
      run       = 1'b1;
      tail_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run          = run && (cap_value[4*i +: 4] == 4'h0) && !cap_dp[i];
         tail_zero[i] = run;
      end
   end

   // Select the current digit's captured fields and blank decision.
   always_comb begin
      cur_nibble = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nibble = cap_value[4*i +: 4];
            cur_dp     = cap_dp[i];
            cur_blank  = cap_blank_lz && (i != 0) && tail_zero[i];
         end
      end
   end

   hex7seg_encoder u_enc (
      .nibble (cur_nibble),
      .dp     (cur_dp),
      .blank  (cur_blank),
      .code   (cur_code)
   );

   // Next state and outputs; bus outputs depend only on registered state.
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      avm_write     = 1'b0;
      avm_address   = 32'h0;
      avm_writedata = 32'h0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid)
               state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            avm_write     = 1'b1;
            avm_address   = BASE_ADDR + 32'(idx) * 32'(STRIDE);
            avm_writedata = {24'h0, cur_code};
            if (!avm_waitrequest && idx == LAST_IDX)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hex_display_updater.sv
// Directed bench for hex_display_updater (6 digits, base 0x3000, stride 16).
module tb_hex_display_updater;

   localparam int ND = 6;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [23:0]   req_value;
   logic [5:0]    req_dp_mask;
   logic          req_blank_lz;
   logic [31:0]   avm_address;
   logic          avm_write;
   logic [31:0]   avm_writedata;
   logic          avm_waitrequest;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_addr [0:7];
   logic [31:0] wr_data [0:7];
   logic [31:0] st_addr [0:7];
   logic [31:0] st_data [0:7];
   int          wr_cnt, st_cnt, done_cyc;

   hex_display_updater dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_value       (req_value),
      .req_dp_mask     (req_dp_mask),
      .req_blank_lz    (req_blank_lz),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request while idle; returns in cycle k+1 after accept edge k.
   task automatic do_req(input logic [23:0] v, input logic [5:0] dp, input logic lz);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      total++;
      if (!req_ready) begin bad++; $display("FAIL req_wait: req_ready got %b want 1", req_ready); end
      req_value = v; req_dp_mask = dp; req_blank_lz = lz; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   // Record each completed write (and each stalled sample) until done.
   task automatic capture(input int stall_digit, input int stall_n);
      int left;
      left = stall_n; wr_cnt = 0; st_cnt = 0; done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            done_cyc = c; avm_waitrequest = 1'b0;
            break;
         end
         avm_waitrequest = 1'b0;
         if (avm_write) begin
            if (wr_cnt == stall_digit && left > 0) begin
               avm_waitrequest = 1'b1; left--;
               if (st_cnt < 8) begin st_addr[st_cnt] = avm_address; st_data[st_cnt] = avm_writedata; end
               st_cnt++;
            end else begin
               if (wr_cnt < 8) begin wr_addr[wr_cnt] = avm_address; wr_data[wr_cnt] = avm_writedata; end
               wr_cnt++;
            end
         end
         tick();
      end
      avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      total++; if ({avm_write, avm_address, avm_writedata} !== 65'h0)
         begin bad++; $display("FAIL rst_avm: got w=%b a=%h d=%h want 0", avm_write, avm_address, avm_writedata); end
      tick(); tick();
      reset_n = 1'b1;
      tick();
      total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_rst: ready=%b busy=%b want 1/0", req_ready, busy); end
   endtask

   task automatic test_basic();
      logic [7:0] exp [0:5];
      exp = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF};
      do_req(24'h012345, 6'h00, 1'b1);
      total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: busy=%b ready=%b want 1/0", busy, req_ready); end
      capture(-1, 0);
      total++; if (wr_cnt !== ND) begin bad++; $display("FAIL basic_cnt: got %0d want %0d", wr_cnt, ND); end
      for (int i = 0; i < ND; i++) begin
         total++; if (wr_addr[i] !== 32'h3000 + 32'(i*16)) begin bad++; $display("FAIL basic_addr%0d: got %h want %h", i, wr_addr[i], 32'h3000 + 32'(i*16)); end
         total++; if (wr_data[i] !== {24'h0, exp[i]}) begin bad++; $display("FAIL basic_data%0d: got %h want %h", i, wr_data[i], exp[i]); end
      end
      total++; if (done_cyc !== 7) begin bad++; $display("FAIL basic_done_cyc: got %0d want 7", done_cyc); end
      tick();
      total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL basic_k8: done=%b ready=%b want 0/1", done, req_ready); end
   endtask

   task automatic test_stall();
      do_req(24'h012345, 6'h00, 1'b1);
      capture(2, 3);
      total++; if (st_cnt !== 3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", st_cnt); end
      for (int i = 0; i < 3; i++) begin
         total++; if (st_addr[i] !== 32'h3020 || st_data[i] !== 32'hB0)
            begin bad++; $display("FAIL stall_hold%0d: got a=%h d=%h want 3020/b0", i, st_addr[i], st_data[i]); end
      end
      total++; if (wr_addr[2] !== 32'h3020 || wr_data[3] !== 32'hA4) begin bad++; $display("FAIL stall_seq: got a2=%h d3=%h want 3020/a4", wr_addr[2], wr_data[3]); end
      total++; if (done_cyc !== 10) begin bad++; $display("FAIL stall_done_cyc: got %0d want 10", done_cyc); end
      tick();
   endtask

   task automatic test_blank_dp();
      logic [7:0] exp [0:5];
      exp = '{8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF};
      do_req(24'h000000, 6'b000100, 1'b1);
      capture(-1, 0);
      for (int i = 0; i < ND; i++) begin
         total++; if (wr_data[i] !== {24'h0, exp[i]}) begin bad++; $display("FAIL blank_data%0d: got %h want %h", i, wr_data[i], exp[i]); end
      end
      tick();
   endtask

   task automatic test_no_blank();
      do_req(24'hFFFFFF, 6'h3F, 1'b0);
      capture(-1, 0);
      for (int i = 0; i < ND; i++) begin
         total++; if (wr_data[i] !== 32'h0E) begin bad++; $display("FAIL noblank_data%0d: got %h want 0e", i, wr_data[i]); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      req_value = 24'h012345; req_dp_mask = 6'h00; req_blank_lz = 1'b1; req_valid = 1'b1;
      tick();
      req_value = 24'h000007;
      for (int c = 1; c <= 7; c++) begin
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_c%0d: got %b want 0", c, req_ready); end
         if (c == 3) begin
            total++; if (avm_writedata !== 32'hB0) begin bad++; $display("FAIL b2b_nocap: got %h want b0", avm_writedata); end
         end
         if (c == 7) begin
            total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
         end
         tick();
      end
      total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_k8: ready=%b busy=%b want 1/0", req_ready, busy); end
      tick();
      req_valid = 1'b0;
      total++; if (busy !== 1'b1 || avm_address !== 32'h3000) begin bad++; $display("FAIL b2b_k9: busy=%b addr=%h want 1/3000", busy, avm_address); end
      capture(-1, 0);
      total++; if (wr_data[0] !== 32'hF8 || wr_data[1] !== 32'hFF) begin bad++; $display("FAIL b2b_second: got d0=%h d1=%h want f8/ff", wr_data[0], wr_data[1]); end
      total++; if (done_cyc !== 7) begin bad++; $display("FAIL b2b_done_cyc: got %0d want 7", done_cyc); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_req(24'h012345, 6'h00, 1'b1);
      tick(); tick(); tick();
      total++; if (avm_write !== 1'b1 || avm_address !== 32'h3030) begin bad++; $display("FAIL rmid_pre: w=%b a=%h want 1/3030", avm_write, avm_address); end
      reset_n = 1'b0;
      #1;
      total++; if (avm_write !== 1'b0 || avm_address !== 32'h0) begin bad++; $display("FAIL rmid_drop: w=%b a=%h want 0/0", avm_write, avm_address); end
      #1;
      reset_n = 1'b1;
      tick();
      total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmid_ready: ready=%b busy=%b want 1/0", req_ready, busy); end
      do_req(24'h000009, 6'h00, 1'b0);
      total++; if (avm_write !== 1'b1 || avm_address !== 32'h3000 || avm_writedata !== 32'h90)
         begin bad++; $display("FAIL rmid_restart: w=%b a=%h d=%h want 1/3000/90", avm_write, avm_address, avm_writedata); end
      capture(-1, 0);
      total++; if (wr_data[5] !== 32'hC0) begin bad++; $display("FAIL rmid_nolz: got %h want c0", wr_data[5]); end
      tick();
   endtask

   initial begin
      req_valid = 1'b0; req_value = '0; req_dp_mask = '0; req_blank_lz = 1'b0;
      avm_waitrequest = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_blank_dp();
      test_no_blank();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
